// File: rtl/eth_wrr_arb_mux.sv
// Weighted round-robin Ethernet frame mux with a RoCE flag and a payload skid buffer.
// Define ETH_WRR_ARB_MUX_STATS_EN to add per-port forwarded-frame counters (m_stat_frames).
module eth_wrr_arb_mux #(
    parameter int S_COUNT      = 4,
    parameter int DATA_WIDTH   = 64,
    parameter int KEEP_ENABLE  = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int USER_WIDTH   = 1,
    parameter int WEIGHT_WIDTH = 4,
    parameter int STAT_WIDTH   = 32
) (
    input  logic                           clk,
    input  logic                           rst,
`ifdef ETH_WRR_ARB_MUX_STATS_EN
    output logic [S_COUNT*STAT_WIDTH-1:0]  m_stat_frames,
`endif
    input  logic [S_COUNT*WEIGHT_WIDTH-1:0] s_weight,
    input  logic [S_COUNT-1:0]             s_eth_hdr_valid,
    output logic [S_COUNT-1:0]             s_eth_hdr_ready,
    input  logic [S_COUNT*48-1:0]          s_eth_dest_mac,
    input  logic [S_COUNT*48-1:0]          s_eth_src_mac,
    input  logic [S_COUNT*16-1:0]          s_eth_type,
    input  logic [S_COUNT-1:0]             s_is_roce_packet,
    input  logic [S_COUNT*DATA_WIDTH-1:0]  s_eth_payload_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0]  s_eth_payload_axis_tkeep,
    input  logic [S_COUNT-1:0]             s_eth_payload_axis_tvalid,
    output logic [S_COUNT-1:0]             s_eth_payload_axis_tready,
    input  logic [S_COUNT-1:0]             s_eth_payload_axis_tlast,
    input  logic [S_COUNT*USER_WIDTH-1:0]  s_eth_payload_axis_tuser,
    output logic                           m_eth_hdr_valid,
    input  logic                           m_eth_hdr_ready,
    output logic [47:0]                    m_eth_dest_mac,
    output logic [47:0]                    m_eth_src_mac,
    output logic [15:0]                    m_eth_type,
    output logic                           m_is_roce_packet,
    output logic [DATA_WIDTH-1:0]          m_eth_payload_axis_tdata,
    output logic [KEEP_WIDTH-1:0]          m_eth_payload_axis_tkeep,
    output logic                           m_eth_payload_axis_tvalid,
    input  logic                           m_eth_payload_axis_tready,
    output logic                           m_eth_payload_axis_tlast,
    output logic [USER_WIDTH-1:0]          m_eth_payload_axis_tuser
);

    localparam int PW = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;

    typedef enum logic [0:0] {ST_IDLE, ST_PAYLOAD} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [PW-1:0]           r_ptr;
    logic [PW-1:0]           r_grant;
    logic [PW-1:0]           w_sel;
    logic                    w_any_req;
    logic                    w_hdr_go;
    logic [WEIGHT_WIDTH-1:0] r_credit;
    logic                    r_credit_valid;
    logic [WEIGHT_WIDTH-1:0] w_weight;
    logic [WEIGHT_WIDTH-1:0] w_rem;
    logic [WEIGHT_WIDTH-1:0] w_rem_n;

    logic                    r_m_hdr_valid;
    logic [47:0]             r_m_dest_mac;
    logic [47:0]             r_m_src_mac;
    logic [15:0]             r_m_type;
    logic                    r_m_roce;

    logic                    r_s_tready;
    logic                    w_s_tready_early;
    logic                    w_in_valid;
    logic                    w_in_last;
    logic                    w_in_fire;
    logic [DATA_WIDTH-1:0]   w_in_data;
    logic [KEEP_WIDTH-1:0]   w_in_keep;
    logic [USER_WIDTH-1:0]   w_in_user;

    logic                    r_m_tvalid;
    logic [DATA_WIDTH-1:0]   r_m_tdata;
    logic [KEEP_WIDTH-1:0]   r_m_tkeep;
    logic                    r_m_tlast;
    logic [USER_WIDTH-1:0]   r_m_tuser;
    logic                    r_t_tvalid;
    logic [DATA_WIDTH-1:0]   r_t_tdata;
    logic [KEEP_WIDTH-1:0]   r_t_tkeep;
    logic                    r_t_tlast;
    logic [USER_WIDTH-1:0]   r_t_tuser;

    // Cyclic priority scan: lowest offset from r_ptr wins.
    always_comb begin
        w_sel = r_ptr;
        for (int i = S_COUNT - 1; i >= 0; i--) begin
            int j;
            j = int'(r_ptr) + i;
            if (j >= S_COUNT) j = j - S_COUNT;
            if (s_eth_hdr_valid[j]) w_sel = PW'(j);
        end
    end

    assign w_any_req = |s_eth_hdr_valid;
    assign w_hdr_go  = !rst && (r_state == ST_IDLE) && w_any_req
                       && (!r_m_hdr_valid || m_eth_hdr_ready);

    always_comb begin
        s_eth_hdr_ready = '0;
        if (w_hdr_go) s_eth_hdr_ready[w_sel] = 1'b1;
    end

    assign w_weight = s_weight[w_sel*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    assign w_rem    = (w_sel == r_ptr && r_credit_valid) ? r_credit :
                      (w_weight == '0) ? WEIGHT_WIDTH'(1) : w_weight;
    assign w_rem_n  = w_rem - WEIGHT_WIDTH'(1);

    assign w_in_valid = s_eth_payload_axis_tvalid[r_grant];
    assign w_in_last  = s_eth_payload_axis_tlast[r_grant];
    assign w_in_data  = s_eth_payload_axis_tdata[r_grant*DATA_WIDTH +: DATA_WIDTH];
    assign w_in_keep  = s_eth_payload_axis_tkeep[r_grant*KEEP_WIDTH +: KEEP_WIDTH];
    assign w_in_user  = s_eth_payload_axis_tuser[r_grant*USER_WIDTH +: USER_WIDTH];
    assign w_in_fire  = r_s_tready && w_in_valid;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:    if (w_hdr_go) w_state_next = ST_PAYLOAD;
            ST_PAYLOAD: if (w_in_fire && w_in_last) w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // Ready only when the beat it admits is guaranteed a free register.
    assign w_s_tready_early = (w_state_next == ST_PAYLOAD)
        && (m_eth_payload_axis_tready || (!r_m_tvalid && !r_t_tvalid));

    always_comb begin
        s_eth_payload_axis_tready = '0;
        if (r_state == ST_PAYLOAD) s_eth_payload_axis_tready[r_grant] = r_s_tready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_ptr          <= '0;
            r_grant        <= '0;
            r_credit       <= '0;
            r_credit_valid <= 1'b0;
            r_m_hdr_valid  <= 1'b0;
            r_m_dest_mac   <= '0;
            r_m_src_mac    <= '0;
            r_m_type       <= '0;
            r_m_roce       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_hdr_go) begin
                r_m_hdr_valid <= 1'b1;
                r_m_dest_mac  <= s_eth_dest_mac[w_sel*48 +: 48];
                r_m_src_mac   <= s_eth_src_mac[w_sel*48 +: 48];
                r_m_type      <= s_eth_type[w_sel*16 +: 16];
                r_m_roce      <= s_is_roce_packet[w_sel];
                r_grant       <= w_sel;
                if (w_rem_n == '0) begin
                    r_ptr          <= (w_sel == PW'(S_COUNT - 1)) ? '0 : w_sel + PW'(1);
                    r_credit_valid <= 1'b0;
                end else begin
                    r_ptr          <= w_sel;
                    r_credit       <= w_rem_n;
                    r_credit_valid <= 1'b1;
                end
            end else if (m_eth_hdr_ready) begin
                r_m_hdr_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_tready <= 1'b0;
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tlast  <= 1'b0;
            r_m_tuser  <= '0;
            r_t_tvalid <= 1'b0;
            r_t_tdata  <= '0;
            r_t_tkeep  <= '0;
            r_t_tlast  <= 1'b0;
            r_t_tuser  <= '0;
        end else begin
            r_s_tready <= w_s_tready_early;
            if (r_s_tready) begin
                if (m_eth_payload_axis_tready || !r_m_tvalid) begin
                    r_m_tvalid <= w_in_valid;
                    r_m_tdata  <= w_in_data;
                    r_m_tkeep  <= w_in_keep;
                    r_m_tlast  <= w_in_last;
                    r_m_tuser  <= w_in_user;
                end else begin
                    r_t_tvalid <= w_in_valid;
                    r_t_tdata  <= w_in_data;
                    r_t_tkeep  <= w_in_keep;
                    r_t_tlast  <= w_in_last;
                    r_t_tuser  <= w_in_user;
                end
            end else if (m_eth_payload_axis_tready) begin
                r_m_tvalid <= r_t_tvalid;
                r_m_tdata  <= r_t_tdata;
                r_m_tkeep  <= r_t_tkeep;
                r_m_tlast  <= r_t_tlast;
                r_m_tuser  <= r_t_tuser;
                r_t_tvalid <= 1'b0;
            end
        end
    end

`ifdef ETH_WRR_ARB_MUX_STATS_EN
    logic [STAT_WIDTH-1:0] r_stat [S_COUNT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < S_COUNT; p++) r_stat[p] <= '0;
        end else if (w_in_fire && w_in_last) begin
            r_stat[r_grant] <= r_stat[r_grant] + STAT_WIDTH'(1);
        end
    end

    always_comb begin
        m_stat_frames = '0;
        for (int p = 0; p < S_COUNT; p++) m_stat_frames[p*STAT_WIDTH +: STAT_WIDTH] = r_stat[p];
    end
`endif

    assign m_eth_hdr_valid           = r_m_hdr_valid;
    assign m_eth_dest_mac            = r_m_dest_mac;
    assign m_eth_src_mac             = r_m_src_mac;
    assign m_eth_type                = r_m_type;
    assign m_is_roce_packet          = r_m_roce;
    assign m_eth_payload_axis_tvalid = r_m_tvalid;
    assign m_eth_payload_axis_tdata  = r_m_tdata;
    assign m_eth_payload_axis_tkeep  = (KEEP_ENABLE != 0) ? r_m_tkeep : {KEEP_WIDTH{1'b1}};
    assign m_eth_payload_axis_tlast  = r_m_tlast;
    assign m_eth_payload_axis_tuser  = r_m_tuser;

endmodule

// File: tb/tb_eth_wrr_arb_mux.sv
// Scoreboard bench for eth_wrr_arb_mux: per-port frame sources, expected order pushed by hand.
// Header and payload monitors pop and compare independently.
module tb_eth_wrr_arb_mux;
    localparam int S  = 4;
    localparam int DW = 64;
    localparam int KW = 8;
    localparam int UW = 1;
    localparam int WW = 4;
    localparam int SW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [S*WW-1:0] s_weight = '0;
    logic [S-1:0]    s_hdr_valid = '0;
    logic [S-1:0]    s_hdr_ready;
    logic [S*48-1:0] s_dest = '0;
    logic [S*48-1:0] s_src = '0;
    logic [S*16-1:0] s_type = '0;
    logic [S-1:0]    s_roce = '0;
    logic [S*DW-1:0] s_tdata = '0;
    logic [S*KW-1:0] s_tkeep = '0;
    logic [S-1:0]    s_tvalid = '0;
    logic [S-1:0]    s_tready;
    logic [S-1:0]    s_tlast = '0;
    logic [S*UW-1:0] s_tuser = '0;
    logic            m_hdr_valid;
    logic            m_hdr_ready = 1'b1;
    logic [47:0]     m_dest, m_src;
    logic [15:0]     m_type;
    logic            m_roce;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic            m_tvalid;
    logic            m_tready = 1'b1;
    logic            m_tlast;
    logic [UW-1:0]   m_tuser;
`ifdef ETH_WRR_ARB_MUX_STATS_EN
    logic [S*SW-1:0] m_stat;
`endif

    eth_wrr_arb_mux #(.S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW),
                      .WEIGHT_WIDTH(WW), .STAT_WIDTH(SW)) dut (
        .clk(clk), .rst(rst),
`ifdef ETH_WRR_ARB_MUX_STATS_EN
        .m_stat_frames(m_stat),
`endif
        .s_weight(s_weight),
        .s_eth_hdr_valid(s_hdr_valid), .s_eth_hdr_ready(s_hdr_ready),
        .s_eth_dest_mac(s_dest), .s_eth_src_mac(s_src), .s_eth_type(s_type),
        .s_is_roce_packet(s_roce),
        .s_eth_payload_axis_tdata(s_tdata), .s_eth_payload_axis_tkeep(s_tkeep),
        .s_eth_payload_axis_tvalid(s_tvalid), .s_eth_payload_axis_tready(s_tready),
        .s_eth_payload_axis_tlast(s_tlast), .s_eth_payload_axis_tuser(s_tuser),
        .m_eth_hdr_valid(m_hdr_valid), .m_eth_hdr_ready(m_hdr_ready),
        .m_eth_dest_mac(m_dest), .m_eth_src_mac(m_src), .m_eth_type(m_type),
        .m_is_roce_packet(m_roce),
        .m_eth_payload_axis_tdata(m_tdata), .m_eth_payload_axis_tkeep(m_tkeep),
        .m_eth_payload_axis_tvalid(m_tvalid), .m_eth_payload_axis_tready(m_tready),
        .m_eth_payload_axis_tlast(m_tlast), .m_eth_payload_axis_tuser(m_tuser)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [112:0] hq[$];
    logic [73:0]  bq[$];
    int nfr[S], add[S], flen[S], seq[S], bt[S], exp_seq[S];
    bit hs[S];
    bit abort = 1'b0;
    bit mon_en = 1'b1;
    int tmode = 0;
    int cyc = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    bit in_frame = 1'b0;

    function automatic logic [112:0] hdr_of(int p, int s);
        logic roce;
        roce = (p == 1 || p == 2);
        return {48'hD00000000000 | 48'(p * 256 + s), 48'h500000000000 | 48'(p),
                16'h0800 + 16'(p), roce};
    endfunction

    function automatic logic [73:0] beat_of(int p, int s, int b, int len);
        return {64'hA000000000000000 | 64'(p * 65536 + s * 256 + b),
                8'hF0 | 8'(b % 16), (b == len - 1), 1'(b % 2)};
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic exp_frame(int p, int len);
        int s;
        s = exp_seq[p];
        exp_seq[p]++;
        hq.push_back(hdr_of(p, s));
        for (int b = 0; b < len; b++) bq.push_back(beat_of(p, s, b, len));
    endtask

    task automatic drive();
        logic [112:0] h;
        logic [73:0]  d;
        for (int p = 0; p < S; p++) begin
            h = hdr_of(p, seq[p]);
            d = beat_of(p, seq[p], bt[p], flen[p]);
            s_hdr_valid[p]      = (nfr[p] > 0) && !hs[p];
            s_dest[p*48 +: 48]  = h[112:65];
            s_src[p*48 +: 48]   = h[64:17];
            s_type[p*16 +: 16]  = h[16:1];
            s_roce[p]           = h[0];
            s_tvalid[p]         = (nfr[p] > 0) && hs[p];
            s_tdata[p*DW +: DW] = d[73:10];
            s_tkeep[p*KW +: KW] = d[9:2];
            s_tlast[p]          = d[1];
            s_tuser[p*UW +: UW] = d[0];
        end
    endtask

    // Source model: sample handshakes mid-cycle, update after the edge.
    initial begin
        logic [S-1:0] hh, dh;
        forever begin
            @(negedge clk);
            hh = s_hdr_valid & s_hdr_ready;
            dh = s_tvalid & s_tready;
            @(posedge clk);
            #1;
            for (int p = 0; p < S; p++) begin
                if (abort) begin
                    nfr[p] = 0; hs[p] = 0; bt[p] = 0; add[p] = 0; seq[p] = 0;
                end else if (nfr[p] > 0) begin
                    if (hh[p]) hs[p] = 1;
                    if (dh[p]) begin
                        if (bt[p] == flen[p] - 1) begin
                            bt[p] = 0; hs[p] = 0; seq[p]++; nfr[p]--;
                        end else begin
                            bt[p]++;
                        end
                    end
                end
                nfr[p] += add[p];
                add[p] = 0;
            end
            abort = 1'b0;
            m_tready = (tmode == 1) ? ~m_tready : 1'b1;
            drive();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!mon_en) begin
                in_frame = 1'b0;
            end else begin
                if (m_hdr_valid && m_hdr_ready) begin
                    if (hq.size() == 0) check("hdr_unexpected", 1, 0);
                    else check("hdr", {m_dest, m_src, m_type, m_roce}, hq.pop_front());
                end
                if (m_tvalid && m_tready) begin
                    if (!in_frame) first_cyc = cyc;
                    in_frame = !m_tlast;
                    if (m_tlast) last_cyc = cyc;
                    if (bq.size() == 0) check("beat_unexpected", 1, 0);
                    else check("beat", {m_tdata, m_tkeep, m_tlast, m_tuser}, bq.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        abort = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int p = 0; p < S; p++) exp_seq[p] = 0;
        tick();
    endtask

    task automatic wait_done(string name, int budget);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            tick();
            n++;
            done = (hq.size() == 0) && (bq.size() == 0);
            for (int p = 0; p < S; p++) if (nfr[p] != 0 || add[p] != 0) done = 1'b0;
        end
        check(name, done, 1);
        repeat (3) tick();
    endtask

    initial begin
        int blocked;
        bit reached;
        for (int p = 0; p < S; p++) begin
            nfr[p] = 0; add[p] = 0; flen[p] = 1; seq[p] = 0; bt[p] = 0; hs[p] = 0;
        end
        tick();
        tick();
        check("rst_hdr_valid", m_hdr_valid, 0);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_hdr_ready", s_hdr_ready, 0);
        check("rst_tready", s_tready, 0);
        do_reset();

        // weights {3,1}: 0,0,0,1,0,0,0,1
        s_weight = 16'h0013;
        flen[0] = 1;
        flen[1] = 1;
        exp_frame(0, 1); exp_frame(0, 1); exp_frame(0, 1); exp_frame(1, 1);
        exp_frame(0, 1); exp_frame(0, 1); exp_frame(0, 1); exp_frame(1, 1);
        add[0] = 6;
        add[1] = 2;
        wait_done("t1_done", 400);

        // zero weights: plain round robin
        do_reset();
        s_weight = 16'h0000;
        for (int p = 0; p < S; p++) flen[p] = 1;
        for (int r = 0; r < 2; r++) for (int p = 0; p < S; p++) exp_frame(p, 1);
        for (int p = 0; p < S; p++) add[p] = 2;
        wait_done("t2_done", 400);

        // 8-beat frame under toggling backpressure, then with steady ready
        do_reset();
        flen[2] = 8;
        tmode = 1;
        exp_frame(2, 8);
        add[2] = 1;
        wait_done("t3_toggle_done", 400);
        tmode = 0;
        exp_frame(2, 8);
        add[2] = 1;
        wait_done("t3_steady_done", 400);
        check("t3_no_gaps", last_cyc - first_cyc, 7);

        // stalled output header blocks the next grant
        do_reset();
        s_weight = 16'h1111;
        flen[0] = 2;
        flen[1] = 2;
        m_hdr_ready = 1'b0;
        exp_frame(0, 2);
        exp_frame(1, 2);
        add[0] = 1;
        add[1] = 1;
        blocked = 0;
        repeat (15) begin
            tick();
            if (s_hdr_ready[1]) blocked++;
        end
        check("t4_blocked_grants", blocked, 0);
        check("t4_hdr_held", m_hdr_valid, 1);
        m_hdr_ready = 1'b1;
        wait_done("t4_done", 400);

        // reset in the middle of a 6-beat frame
        do_reset();
        s_weight = 16'h1111;
        mon_en = 1'b0;
        flen[2] = 6;
        add[2] = 1;
        reached = 1'b0;
        for (int n = 0; n < 50 && !reached; n++) begin
            tick();
            reached = (bt[2] >= 3);
        end
        check("t5_reach_beat3", reached, 1);
        rst = 1'b1;
        abort = 1'b1;
        tick();
        check("t5_hdr_valid", m_hdr_valid, 0);
        check("t5_tvalid", m_tvalid, 0);
        check("t5_hdr_ready", s_hdr_ready, 0);
        check("t5_tready", s_tready, 0);
        rst = 1'b0;
        for (int p = 0; p < S; p++) exp_seq[p] = 0;
        tick();
        mon_en = 1'b1;
        flen[1] = 3;
        flen[3] = 3;
        exp_frame(1, 3);
        exp_frame(3, 3);
        add[1] = 1;
        add[3] = 1;
        wait_done("t5_done", 400);

`ifdef ETH_WRR_ARB_MUX_STATS_EN
        do_reset();
        s_weight = 16'h0000;
        flen[1] = 1;
        flen[3] = 1;
        exp_frame(1, 1); exp_frame(3, 1); exp_frame(1, 1); exp_frame(3, 1);
        exp_frame(1, 1); exp_frame(1, 1); exp_frame(1, 1);
        add[1] = 5;
        add[3] = 2;
        wait_done("t6_done", 400);
        check("t6_stat0", m_stat[0*SW +: SW], 0);
        check("t6_stat1", m_stat[1*SW +: SW], 5);
        check("t6_stat2", m_stat[2*SW +: SW], 0);
        check("t6_stat3", m_stat[3*SW +: SW], 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/eth_wrr_arb_mux.md
Name: eth_wrr_arb_mux

Overview:
Multiplexes S_COUNT Ethernet frame streams onto one output. Each stream is a header plus an AXI-Stream payload. Arbitration is weighted round-robin, per frame, using runtime per-port weights. Carries a per-port RoCE flag alongside the header, and has a registered two-entry skid buffer on the payload path for full throughput. Sits between the RoCE/UDP TX engines and the Ethernet MAC TX path.

Parameters:
S_COUNT, 4, number of input ports (>=2)
DATA_WIDTH, 64, payload tdata width
KEEP_ENABLE, (DATA_WIDTH>8), tkeep propagated; when 0, m tkeep is driven all-ones
KEEP_WIDTH, DATA_WIDTH/8, tkeep width
USER_WIDTH, 1, tuser width
WEIGHT_WIDTH, 4, width of each per-port weight
STAT_WIDTH, 32, per-port frame counter width (optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
s_weight  in  S_COUNT*WEIGHT_WIDTH  frames per round for each port; 0 is treated as 1
s_eth_hdr_valid / s_eth_hdr_ready  in/out  S_COUNT  header handshake per port
s_eth_dest_mac, s_eth_src_mac  in  S_COUNT*48  per-port MACs
s_eth_type  in  S_COUNT*16  per-port ethertype
s_is_roce_packet  in  S_COUNT  per-port RoCE flag
s_eth_payload_axis_tdata/tkeep/tuser  in  S_COUNT*(DATA_WIDTH/KEEP_WIDTH/USER_WIDTH)  payload
s_eth_payload_axis_tvalid/tready/tlast  in/out/in  S_COUNT  payload handshake
m_eth_hdr_valid / m_eth_hdr_ready  out/in  1  output header handshake
m_eth_dest_mac, m_eth_src_mac, m_eth_type, m_is_roce_packet  out  48,48,16,1  output header
m_eth_payload_axis_tdata/tkeep/tvalid/tready/tlast/tuser  out(tready in)  DATA_WIDTH/KEEP_WIDTH/1/1/1/USER_WIDTH  output payload
m_stat_frames  out  S_COUNT*STAT_WIDTH  per-port frames forwarded (present only with ETH_WRR_ARB_MUX_STATS_EN)

Behaviour:
- Reset values:
  - All outputs 0: hdr_valid, payload tvalid, all s_hdr_ready, all s_tready.
  - State IDLE; round-robin pointer ptr=0; credit_valid=0; header and data registers hold 0.
- FSM IDLE:
  - sel = first port with hdr_valid, scanning cyclically from ptr.
  - If any port is requesting and (!m_eth_hdr_valid || m_eth_hdr_ready): s_eth_hdr_ready[sel]=1 combinationally; all other bits 0.
  - On that handshake: capture the sel header fields and s_is_roce_packet[sel] into the output registers. m_eth_hdr_valid=1 on the next cycle (1-cycle latency). grant<=sel; go to PAYLOAD.
- FSM PAYLOAD:
  - s_tready[grant] = registered skid-ready; all other s_tready 0.
  - On an accepted beat with tlast: go to IDLE. The next header grant can occur the following cycle.
  - Payload beats presented before their header is granted are never consumed.
- Weight/credit update, on each grant g:
  - rem = (g==ptr && credit_valid) ? credit : max(s_weight[g],1); rem_n = rem-1.
  - If rem_n==0: ptr<=(g+1) mod S_COUNT; credit_valid<=0.
  - Else: ptr<=g; credit<=rem_n; credit_valid<=1.
  - Weights are sampled only at a grant; changing them mid-round affects only ports not currently holding credit.
- Header register:
  - Clears when m_eth_hdr_ready is high while valid.
  - Independent of the payload path, so the next header may be granted while the previous payload is still draining.
- Skid buffer: output register plus temp register.
  - Registered input ready = m_tready || both registers empty, and only in PAYLOAD.
  - Sustains one beat/cycle; no beat lost or duplicated under any m_tready pattern.
  - Passes tdata/tkeep/tlast/tuser unmodified; order preserved.
- Boundary conditions:
  - Source dropping hdr_valid before it is granted: legal; no grant is issued.
  - Single-beat frames: legal.
  - Reset mid-frame: all state cleared on the next edge; the partial frame is truncated and downstream must tolerate it.
  - ptr wraps from S_COUNT-1 to 0.

Optional Feature:
ETH_WRR_ARB_MUX_STATS_EN
- Defined: adds m_stat_frames. Counter p increments by 1 on each accepted tlast beat from port p; wraps modulo 2^STAT_WIDTH; reset to 0.
- Undefined: the port and counters are absent; no other behaviour changes.

Test Plan:
- Weights {3,1}, ports 0 and 1 always valid, 1-beat frames -> output frame source order 0,0,0,1,0,0,0,1; m_is_roce_packet matches each source.
- Weights all 0, 4 ports always valid -> plain round-robin order 0,1,2,3,0,...
- Port 2 sends an 8-beat frame, data 0..7, with m_tready toggling 1,0,1,0 -> 8 beats out in order, tlast only on beat 7, no gaps while m_tready stays 1.
- m_eth_hdr_ready held 0 after first header, second port valid -> no s_hdr_ready for the second frame until the first header is accepted.
- rst asserted at beat 3 of a 6-beat frame -> next cycle all valids/readies 0 and ptr=0; the subsequent frame is forwarded cleanly.
- STATS_EN defined, 5 frames port 1, 2 frames port 3 -> m_stat_frames[1]=5, m_stat_frames[3]=2, others 0.
